// File: rtl/car_collision_pkg.sv
// Shared constants, FSM encoding and snapshot payload for the car/frog collision checker.
package car_collision_pkg;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned Y_W     = POS_W + 1;
  localparam int unsigned CAR_NUM = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned GRACE_W = 8;

  localparam int unsigned CAR_W_DEF        = 32;
  localparam int unsigned FROG_W_DEF       = 32;
  localparam int unsigned FROG_H_DEF       = 32;
  localparam int unsigned LANE_H_DEF       = 32;
  localparam int unsigned LANE_Y_BASE_DEF  = 96;
  localparam int unsigned LIVES_INIT_DEF   = 3;
  localparam int unsigned GRACE_FRAMES_DEF = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  typedef struct packed {
    logic [CAR_NUM-1:0][POS_W-1:0] car_x;
    logic [POS_W-1:0]              frog_x;
    logic [POS_W-1:0]              frog_y;
  } snap_t;

  // Top y of the lane driven by car lane_idx (0-based), widened so later sums cannot overflow.
  function automatic logic [Y_W-1:0] lane_top(input int unsigned base, input int unsigned height,
                                              input logic [IDX_W-1:0] lane_idx);
    return Y_W'(base + height * 32'(lane_idx));
  endfunction

endpackage

// File: rtl/car_overlap.sv
// Combinational overlap test between one car sprite and the frog sprite, horizontal axis wrapping mod 1024.
module car_overlap
  import car_collision_pkg::*;
#(
  parameter int unsigned CAR_W       = CAR_W_DEF,
  parameter int unsigned FROG_W      = FROG_W_DEF,
  parameter int unsigned FROG_H      = FROG_H_DEF,
  parameter int unsigned LANE_H      = LANE_H_DEF,
  parameter int unsigned LANE_Y_BASE = LANE_Y_BASE_DEF
) (
  input  logic [POS_W-1:0] car_x,
  input  logic [IDX_W-1:0] lane_idx,
  input  logic [POS_W-1:0] frog_x,
  input  logic [POS_W-1:0] frog_y,
  output logic             overlap_c
);

  logic [POS_W-1:0] dx;
  logic [POS_W-1:0] dx_neg;
  logic [Y_W-1:0]   top;
  logic [Y_W-1:0]   fy;
  logic             h_hit;
  logic             v_hit;

  // Either sprite may sit to the left of the other, so test both wrapped distances.
  always_comb begin
    dx        = frog_x - car_x;
    dx_neg    = POS_W'(0) - dx;
    h_hit     = (32'(dx) < CAR_W) || (32'(dx_neg) < FROG_W);
    top       = lane_top(LANE_Y_BASE, LANE_H, lane_idx);
    fy        = Y_W'(frog_y);
    v_hit     = (fy < top + Y_W'(LANE_H)) && ((fy + Y_W'(FROG_H)) > top);
    overlap_c = h_hit && v_hit;
  end

endmodule

// File: rtl/car_collision.sv
// Per-frame frog collision checker: snapshots positions, scans eight cars through one comparator, tracks lives.
// Optional hit_idx output is enabled by defining CAR_COLLISION_HIT_INDEX_EN.
module car_collision
  import car_collision_pkg::*;
#(
  parameter int unsigned CAR_W        = CAR_W_DEF,
  parameter int unsigned FROG_W       = FROG_W_DEF,
  parameter int unsigned FROG_H       = FROG_H_DEF,
  parameter int unsigned LANE_H       = LANE_H_DEF,
  parameter int unsigned LANE_Y_BASE  = LANE_Y_BASE_DEF,
  parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF,
  parameter int unsigned GRACE_FRAMES = GRACE_FRAMES_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               frame_tick,
  input  logic [POS_W-1:0]   car_x1,
  input  logic [POS_W-1:0]   car_x2,
  input  logic [POS_W-1:0]   car_x3,
  input  logic [POS_W-1:0]   car_x4,
  input  logic [POS_W-1:0]   car_x5,
  input  logic [POS_W-1:0]   car_x6,
  input  logic [POS_W-1:0]   car_x7,
  input  logic [POS_W-1:0]   car_x8,
  input  logic [POS_W-1:0]   frog_x,
  input  logic [POS_W-1:0]   frog_y,
  input  logic               lives_reload,
  output logic               hit,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               busy
`ifdef CAR_COLLISION_HIT_INDEX_EN
  ,
  output logic [IDX_W-1:0]   hit_idx
`endif
);

  state_e             state_q;
  state_e             state_d;
  snap_t              snap_q;
  logic [IDX_W-1:0]   idx_q;
  logic               hit_acc_q;
  logic               grace_act_q;
  logic               fire_q;
  logic [GRACE_W-1:0] grace_q;
  logic [POS_W-1:0]   car_sel;
  logic               ov_c;
  logic               start_c;
  logic               fire_c;
  logic               busy_d;

  assign car_sel = snap_q.car_x[idx_q];

  car_overlap #(
    .CAR_W       (CAR_W),
    .FROG_W      (FROG_W),
    .FROG_H      (FROG_H),
    .LANE_H      (LANE_H),
    .LANE_Y_BASE (LANE_Y_BASE)
  ) u_overlap (
    .car_x     (car_sel),
    .lane_idx  (idx_q),
    .frog_x    (snap_q.frog_x),
    .frog_y    (snap_q.frog_y),
    .overlap_c (ov_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Reload wins over everything and always parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    if (lives_reload) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (frame_tick && !game_over) state_d = ST_SCAN;
        ST_SCAN:   if (idx_q == IDX_W'(CAR_NUM - 1)) state_d = ST_REPORT;
        ST_REPORT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start_c = 1'b0;
    fire_c  = 1'b0;
    busy_d  = 1'b0;
    start_c = (state_q == ST_IDLE) && frame_tick && !game_over && !lives_reload;
    fire_c  = (state_q == ST_REPORT) && hit_acc_q && !grace_act_q &&
              (lives != '0) && !lives_reload;
    busy_d  = (state_d != ST_IDLE);
  end

  // Grace shielding is latched at the tick, so GRACE_FRAMES whole frames are skipped after a hit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_q      <= '0;
      idx_q       <= '0;
      hit_acc_q   <= 1'b0;
      grace_act_q <= 1'b0;
      grace_q     <= '0;
      fire_q      <= 1'b0;
      hit         <= 1'b0;
      lives       <= LIVES_W'(LIVES_INIT);
      game_over   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy   <= busy_d;
      fire_q <= fire_c;
      if (lives_reload) begin
        lives     <= LIVES_W'(LIVES_INIT);
        game_over <= 1'b0;
        grace_q   <= '0;
        hit       <= 1'b0;
        fire_q    <= 1'b0;
      end else begin
        hit <= fire_q;
        if (start_c) begin
          snap_q      <= '{car_x: {car_x8, car_x7, car_x6, car_x5, car_x4, car_x3, car_x2, car_x1},
                           frog_x: frog_x, frog_y: frog_y};
          hit_acc_q   <= 1'b0;
          idx_q       <= '0;
          grace_act_q <= (grace_q != '0);
          if (grace_q != '0) grace_q <= grace_q - GRACE_W'(1);
        end
        if (state_q == ST_SCAN) begin
          hit_acc_q <= hit_acc_q | ov_c;
          idx_q     <= idx_q + IDX_W'(1);
        end
        if (fire_c) begin
          lives     <= lives - LIVES_W'(1);
          grace_q   <= GRACE_W'(GRACE_FRAMES);
          game_over <= (lives == LIVES_W'(1));
        end
      end
    end
  end

`ifdef CAR_COLLISION_HIT_INDEX_EN
  logic [IDX_W-1:0] first_q;

  // First overlapping car in scan order is the lowest-numbered one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_q <= '0;
      hit_idx <= '0;
    end else begin
      if ((state_q == ST_SCAN) && ov_c && !hit_acc_q) first_q <= idx_q;
      if (fire_c) hit_idx <= first_q;
    end
  end
`endif

endmodule

// File: tb/tb_car_collision.sv
// Self-checking bench for car_collision against a frame-level behavioural model.
module tb_car_collision;

  localparam int TB_GRACE = 2;
  localparam int LIVES0   = 3;

  logic       CLK;
  logic       RST_N;
  logic       frame_tick;
  logic       lives_reload;
  logic [9:0] cx [8];
  logic [9:0] fx;
  logic [9:0] fy;
  logic       hit;
  logic [2:0] lives;
  logic       game_over;
  logic       busy;
`ifdef CAR_COLLISION_HIT_INDEX_EN
  logic [2:0] hit_idx;
`endif

  int checks   = 0;
  int failures = 0;
  int m_lives;
  int m_grace;
  bit m_go;
  int m_hit_idx;

  car_collision #(.GRACE_FRAMES(TB_GRACE)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .frame_tick   (frame_tick),
    .car_x1       (cx[0]),
    .car_x2       (cx[1]),
    .car_x3       (cx[2]),
    .car_x4       (cx[3]),
    .car_x5       (cx[4]),
    .car_x6       (cx[5]),
    .car_x7       (cx[6]),
    .car_x8       (cx[7]),
    .frog_x       (fx),
    .frog_y       (fy),
    .lives_reload (lives_reload),
    .hit          (hit),
    .lives        (lives),
    .game_over    (game_over),
    .busy         (busy)
`ifdef CAR_COLLISION_HIT_INDEX_EN
    ,
    .hit_idx      (hit_idx)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  // Sprite rectangles on a 1024-wide wrapping road; lane k spans [96+32(k-1), +32).
  function automatic bit m_overlap(int car_x, int lane, int frog_x, int frog_y);
    int dx;
    int top;
    bit h;
    bit v;
    dx  = ((frog_x - car_x) % 1024 + 1024) % 1024;
    h   = (dx < 32) || (((1024 - dx) % 1024) < 32);
    top = 96 + 32 * (lane - 1);
    v   = (frog_y < top + 32) && (frog_y + 32 > top);
    return h && v;
  endfunction

  task automatic model_frame(output bit accepted, output bit exp_hit);
    bit shielded;
    int first;
    first    = -1;
    exp_hit  = 1'b0;
    accepted = !m_go;
    if (!accepted) return;
    shielded = (m_grace != 0);
    if (m_grace > 0) m_grace--;
    for (int k = 1; k <= 8; k++)
      if (first < 0 && m_overlap(int'(cx[k-1]), k, int'(fx), int'(fy))) first = k - 1;
    if (first >= 0 && !shielded && m_lives > 0) begin
      exp_hit   = 1'b1;
      m_lives   = m_lives - 1;
      m_grace   = TB_GRACE;
      m_go      = (m_lives == 0);
      m_hit_idx = first;
    end
  endtask

  task automatic set_far(input int x);
    for (int k = 0; k < 8; k++) cx[k] = 10'(x);
  endtask

  task automatic randomize_pos();
    fx = 10'($urandom_range(0, 1023));
    fy = 10'($urandom_range(60, 380));
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) cx[k] = 10'(int'(fx) + int'($urandom_range(0, 90)) - 45);
      else                           cx[k] = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic pulse_reload();
    @(negedge CLK);
    lives_reload = 1'b1;
    @(posedge CLK);
    #1;
    lives_reload = 1'b0;
    m_lives = LIVES0;
    m_grace = 0;
    m_go    = 1'b0;
    checks++;
    if (lives !== 3'd3 || game_over !== 1'b0 || hit !== 1'b0) begin
      failures++;
      $display("FAIL reload: got lives=%0d go=%b hit=%b exp lives=3 go=0 hit=0", lives, game_over, hit);
    end
  endtask

  // One frame: tick, then watch busy/hit cycle by cycle and lives once the report has landed.
  task automatic run_frame(input string tag, input bit scramble);
    bit acc;
    bit eh;
    @(negedge CLK);
    frame_tick = 1'b1;
    model_frame(acc, eh);
    @(posedge CLK);
    #1;
    frame_tick = 1'b0;
    checks++;
    if (busy !== acc) begin
      failures++;
      $display("FAIL %s busy@0: got=%b exp=%b", tag, busy, acc);
    end
    if (scramble) randomize_pos();
    for (int e = 1; e <= 11; e++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (busy !== (acc && e <= 8)) begin
        failures++;
        $display("FAIL %s busy@%0d: got=%b exp=%b", tag, e, busy, (acc && e <= 8));
      end
      checks++;
      if (hit !== (eh && e == 10)) begin
        failures++;
        $display("FAIL %s hit@%0d: got=%b exp=%b", tag, e, hit, (eh && e == 10));
      end
      if (e == 10) begin
        checks++;
        if (lives !== 3'(m_lives) || game_over !== m_go) begin
          failures++;
          $display("FAIL %s lives: got lives=%0d go=%b exp lives=%0d go=%b", tag, lives, game_over, m_lives, m_go);
        end
`ifdef CAR_COLLISION_HIT_INDEX_EN
        checks++;
        if (hit_idx !== 3'(m_hit_idx)) begin
          failures++;
          $display("FAIL %s hit_idx: got=%0d exp=%0d", tag, hit_idx, m_hit_idx);
        end
`endif
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; frame_tick = 1'b0; lives_reload = 1'b0;
    fx = '0; fy = '0; set_far(0);
    #12;
    checks++;
    if (hit !== 1'b0 || lives !== 3'd3 || game_over !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: got hit=%b lives=%0d go=%b busy=%b exp 0/3/0/0", hit, lives, game_over, busy);
    end
`ifdef CAR_COLLISION_HIT_INDEX_EN
    checks++;
    if (hit_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset hit_idx: got=%0d exp=0", hit_idx);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    m_lives = LIVES0; m_grace = 0; m_go = 1'b0; m_hit_idx = 0;
  endtask

  task automatic test_basic();
    set_far(700); cx[0] = 10'd110; fx = 10'd100; fy = 10'd96;
    run_frame("basic", 1'b0);
    checks++;
    if (lives !== 3'd2) begin
      failures++;
      $display("FAIL basic lives: got=%0d exp=2", lives);
    end
  endtask

  task automatic test_wrap();
    pulse_reload();
    set_far(700); cx[2] = 10'd1010; fx = 10'd10; fy = 10'd160;
    run_frame("wrap_hit", 1'b0);
    pulse_reload();
    fx = 10'd60;
    run_frame("wrap_miss", 1'b0);
  endtask

  task automatic test_grace();
    int nhits;
    nhits = 0;
    pulse_reload();
    set_far(700); cx[0] = 10'd110; fx = 10'd100; fy = 10'd96;
    for (int f = 1; f <= 5; f++) begin
      run_frame("grace", 1'b0);
      repeat (88) @(posedge CLK);
    end
    checks++;
    if (lives !== 3'd1) begin
      failures++;
      $display("FAIL grace lives: got=%0d exp=1", lives);
    end
  endtask

  task automatic test_game_over();
    int guard;
    guard = 0;
    pulse_reload();
    set_far(700); cx[0] = 10'd110; fx = 10'd100; fy = 10'd96;
    while (!m_go && guard < 12) begin
      run_frame("gameover", 1'b0);
      guard++;
    end
    checks++;
    if (game_over !== 1'b1 || lives !== 3'd0) begin
      failures++;
      $display("FAIL gameover state: got go=%b lives=%0d exp go=1 lives=0", game_over, lives);
    end
    run_frame("gameover_ignored", 1'b0);
    pulse_reload();
  endtask

  task automatic test_straddle();
    pulse_reload();
    set_far(700); cx[1] = 10'd300; fx = 10'd300; fy = 10'd112;
    run_frame("straddle", 1'b0);
`ifdef CAR_COLLISION_HIT_INDEX_EN
    checks++;
    if (hit_idx !== 3'd1) begin
      failures++;
      $display("FAIL straddle hit_idx: got=%0d exp=1", hit_idx);
    end
`endif
  endtask

  task automatic test_busy_overlap();
    bit acc;
    bit eh;
    int nhits;
    nhits = 0;
    pulse_reload();
    set_far(700); cx[0] = 10'd110; fx = 10'd100; fy = 10'd96;
    @(negedge CLK);
    frame_tick = 1'b1;
    model_frame(acc, eh);
    @(posedge CLK);
    #1;
    frame_tick = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge CLK);
      #1;
      if (hit === 1'b1) nhits++;
      checks++;
      if (busy !== (acc && e <= 8)) begin
        failures++;
        $display("FAIL busy_overlap busy@%0d: got=%b exp=%b", e, busy, (acc && e <= 8));
      end
      if (e == 2) frame_tick = 1'b1;
      if (e == 3) frame_tick = 1'b0;
    end
    checks++;
    if (nhits != 1) begin
      failures++;
      $display("FAIL busy_overlap hits: got=%0d exp=1", nhits);
    end
    checks++;
    if (lives !== 3'(m_lives)) begin
      failures++;
      $display("FAIL busy_overlap lives: got=%0d exp=%0d", lives, m_lives);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_reload();
      randomize_pos();
      run_frame("random", 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_scan();
    bit acc;
    bit eh;
    pulse_reload();
    set_far(700); cx[0] = 10'd110; fx = 10'd100; fy = 10'd96;
    @(negedge CLK);
    frame_tick = 1'b1;
    model_frame(acc, eh);
    @(posedge CLK);
    #1;
    frame_tick = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0 || lives !== 3'd3 || game_over !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_scan: got hit=%b lives=%0d go=%b busy=%b exp 0/3/0/0", hit, lives, game_over, busy);
    end
`ifdef CAR_COLLISION_HIT_INDEX_EN
    checks++;
    if (hit_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_scan hit_idx: got=%0d exp=0", hit_idx);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    m_lives = LIVES0; m_grace = 0; m_go = 1'b0; m_hit_idx = 0;
    run_frame("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_grace();
    test_game_over();
    test_straddle();
    test_busy_overlap();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
